// File: rtl/mp_mac_row.sv
// mp_mac_row -- multi-limb row multiply-accumulate, R = A*b + C.
//
// A and C are N limbs of L bits. b is a single K-bit digit. One limb product
// a_i*b + c_i is issued per cycle into a MUL_LAT-deep pipe. A serial carry
// stage then folds each product into the running carry, in limb order. Only
// one row is in flight at a time.
//
// Optional feature, enabled by defining MP_MAC_ROW_ZERO_SKIP_EN:
//   If b == 0 when a row is accepted, the pipe is bypassed.
//   The result is {K'b0, C}, and out_valid rises two cycles after accept.
//
// Ports:
//   clk        clock; all logic updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set valid
//   in_ready   block idle and able to accept a row
//   in_a       A; limb i = in_a[i*L +: L]
//   in_b       digit b
//   in_c       addend C; same limb layout as in_a
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   out_r      R = A*b + C, exact
module mp_mac_row #(
  parameter int unsigned N       = 16,
  parameter int unsigned L       = 17,
  parameter int unsigned K       = 17,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*L-1:0]   in_a,
  input  logic [K-1:0]     in_b,
  input  logic [N*L-1:0]   in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*L+K-1:0] out_r
);

  // p_i < 2^(L+K) and carry < 2^(K+1), so L+K+1 bits hold p_i + carry exactly.
  localparam int unsigned PW = L + K + 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [N*L-1:0] a_q, c_q, res_q, res_next;
  logic [K-1:0]   b_q, top_q;
  logic [CW-1:0]  cnt_q;
  logic [K:0]     carry_q;

  logic [PW-1:0]      pipe_p_q [MUL_LAT];
  logic [MUL_LAT-1:0] pipe_v_q;
  logic [MUL_LAT-1:0] pipe_last_q;
  // Set on the cycle after the last limb has been folded into carry_q.
  logic               cs_last_q;

  logic          accept, issue, issue_last, zero_skip;
  logic [PW-1:0] prod, t;

  assign accept     = (state_q == StIdle) && in_valid;
  assign issue      = (state_q == StIssue);
  assign issue_last = issue && (cnt_q == CW'(N - 1));

`ifdef MP_MAC_ROW_ZERO_SKIP_EN
  assign zero_skip = (in_b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Operand registers shift right once per issue, so limb i is always at the bottom.
  assign prod = PW'(a_q[L-1:0]) * PW'(b_q) + PW'(c_q[L-1:0]);
  assign t    = pipe_p_q[MUL_LAT-1] + PW'(carry_q);

  // Result limbs enter at the top, so after N limbs limb 0 sits at the bottom.
  always_comb begin
    res_next                = res_q >> L;
    res_next[N*L-1 -: L]    = t[L-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Zero-skip rows spend one cycle in StDrain.
        // That gives them their fixed two-cycle latency.
        if (in_valid) state_d = zero_skip ? StDrain : StIssue;
      end
      StIssue: begin
        if (issue_last) state_d = StDrain;
      end
      StDrain: begin
        if (cs_last_q) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign out_r = {top_q, res_q};

  // Datapath: operand registers, multiply-add pipe, carry stage
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= '0;
      res_q       <= '0;
      top_q       <= '0;
      pipe_v_q    <= '0;
      pipe_last_q <= '0;
      cs_last_q   <= 1'b0;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        pipe_p_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0]    <= issue;
      pipe_last_q[0] <= issue_last;
      pipe_p_q[0]    <= prod;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        pipe_v_q[i]    <= pipe_v_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
        pipe_p_q[i]    <= pipe_p_q[i-1];
      end

      if (issue) begin
        a_q   <= a_q >> L;
        c_q   <= c_q >> L;
        cnt_q <= cnt_q + CW'(1);
      end

      if (pipe_v_q[MUL_LAT-1]) begin
        carry_q <= t[PW-1:L];
        res_q   <= res_next;
      end
      cs_last_q <= pipe_v_q[MUL_LAT-1] & pipe_last_q[MUL_LAT-1];

      // The final carry is below 2^K, so its top bit is always zero here.
      if ((state_q == StDrain) && cs_last_q) begin
        top_q <= carry_q[K-1:0];
      end

      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        c_q     <= in_c;
        cnt_q   <= '0;
        carry_q <= '0;
        if (zero_skip) begin
          res_q     <= in_c;
          cs_last_q <= 1'b1;
        end
      end
    end
  end

endmodule
